// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: execute stage of the MIPS-Lite pipeline.
// Holds the operand forwarding muxes, the single-cycle ALU and a multi-cycle
// shift-add multiply unit with HI/LO registers. While the multiply unit is
// working it stalls PC/IF-ID/ID-EX and injects bubbles into EX/MEM.
// Optional build macro: MDU_DIVU_EN adds divu (restoring division) on the
// same iterative datapath.
module ex_stage_mdu #(
    parameter int unsigned MDU_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [4:0]  shamt_in,
    input  logic [5:0]  funct_in,
    input  logic [31:0] immed_in,
    input  logic [31:0] rd1_in,
    input  logic [31:0] rd2_in,
    input  logic [1:0]  wb_in,
    input  logic [1:0]  mem_in,
    input  logic [3:0]  exe_in,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_data,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic [31:0] alu_out,
    output logic [31:0] store_out,
    output logic [4:0]  dst_out,
    output logic [1:0]  wb_out,
    output logic [1:0]  mem_out,
    output logic        zero_out,
    output logic        stall,
    output logic        mdu_busy
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PLEN  = 2 * XLEN;
    localparam int unsigned CNT_W = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_CYCLES - 1);

    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
`ifdef MDU_DIVU_EN
    localparam logic [5:0] F_DIVU  = 6'h1B;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    mdu_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   op_a_q;
    logic [PLEN-1:0]   prod_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
`ifdef MDU_DIVU_EN
    logic [XLEN-1:0]   op_b_q;
    logic              is_div_q;
`endif

    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;
    logic [XLEN-1:0]   op2;
    logic              is_rtype;
    logic              mul_req_c;
    logic              div_req_c;
    logic              mdu_req_c;
    logic [XLEN:0]     mul_sum;
    logic [PLEN-1:0]   mul_next;
    logic [PLEN-1:0]   prod_next;
`ifdef MDU_DIVU_EN
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   rem_diff;
    logic [PLEN-1:0]   div_next;
`endif

    // Operand forwarding: EX/MEM result wins over MEM/WB, register 0 never forwards.
    always_comb begin
        fwd_a = rd1_in;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs_in))
            fwd_a = exmem_data;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_in))
            fwd_a = memwb_data;

        fwd_b = rd2_in;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt_in))
            fwd_b = exmem_data;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_in))
            fwd_b = memwb_data;
    end

    assign op2       = exe_in[2] ? immed_in : fwd_b;
    assign store_out = fwd_b;
    assign dst_out   = exe_in[3] ? rd_in : rt_in;

    // Decode which instructions launch the iterative unit.
    assign is_rtype  = (exe_in[1:0] == 2'b10);
    assign mul_req_c = is_rtype && (funct_in == F_MULTU);
`ifdef MDU_DIVU_EN
    assign div_req_c = is_rtype && (funct_in == F_DIVU);
`else
    assign div_req_c = 1'b0;
`endif
    assign mdu_req_c = mul_req_c || div_req_c;

    // Single-cycle ALU plus HI/LO moves; unknown functs yield zero.
    always_comb begin
        alu_out = '0;
        case (exe_in[1:0])
            2'b00: alu_out = fwd_a + op2;
            2'b01: alu_out = fwd_a - op2;
            2'b11: alu_out = fwd_a | op2;
            default: begin
                case (funct_in)
                    F_ADD:   alu_out = fwd_a + op2;
                    F_SUB:   alu_out = fwd_a - op2;
                    F_AND:   alu_out = fwd_a & op2;
                    F_OR:    alu_out = fwd_a | op2;
                    F_SLT:   alu_out = ($signed(fwd_a) < $signed(op2)) ? 32'd1 : 32'd0;
                    F_SRL:   alu_out = fwd_b >> shamt_in;
                    F_MFHI:  alu_out = hi_q;
                    F_MFLO:  alu_out = lo_q;
                    default: alu_out = '0;
                endcase
            end
        endcase
    end

    assign zero_out = (alu_out == '0);

    // Stall while a multi-cycle op is being launched or iterating; bubble downstream.
    assign stall    = !rst && (((state_q == IDLE) && mdu_req_c) || (state_q == BUSY));
    assign mdu_busy = (state_q != IDLE);
    assign wb_out   = stall ? 2'b00 : wb_in;
    assign mem_out  = stall ? 2'b00 : mem_in;

    // One iteration of the datapath: shift-add multiply (and restoring divide).
    always_comb begin
        mul_sum  = {1'b0, prod_q[PLEN-1:XLEN]} + (prod_q[0] ? {1'b0, op_a_q} : '0);
        mul_next = {mul_sum, prod_q[XLEN-1:1]};
`ifdef MDU_DIVU_EN
        rem_sh   = prod_q[PLEN-1:XLEN-1];
        rem_diff = {1'b0, rem_sh} - {2'b00, op_b_q};
        if (!rem_diff[XLEN+1])
            div_next = {rem_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        else
            div_next = {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        prod_next = is_div_q ? div_next : mul_next;
`else
        prod_next = mul_next;
`endif
    end

    // MDU control FSM with operand latch, iteration counter and HI/LO update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_DIVU_EN
            op_b_q   <= '0;
            is_div_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (mdu_req_c) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                        op_a_q  <= fwd_a;
                        prod_q  <= div_req_c ? {32'd0, fwd_a} : {32'd0, fwd_b};
`ifdef MDU_DIVU_EN
                        op_b_q   <= fwd_b;
                        is_div_q <= div_req_c;
`endif
                    end
                end
                BUSY: begin
                    prod_q <= prod_next;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        hi_q    <= prod_next[PLEN-1:XLEN];
                        lo_q    <= prod_next[XLEN-1:0];
`ifdef MDU_DIVU_EN
                        if (is_div_q && (op_b_q == '0)) begin
                            hi_q <= op_a_q;
                            lo_q <= '1;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb_ex_stage_mdu: directed self-checking bench for ex_stage_mdu.
module tb_ex_stage_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_in, rt_in, rd_in, shamt_in;
    logic [5:0]  funct_in;
    logic [31:0] immed_in, rd1_in, rd2_in;
    logic [1:0]  wb_in, mem_in;
    logic [3:0]  exe_in;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic [31:0] alu_out, store_out;
    logic [4:0]  dst_out;
    logic [1:0]  wb_out, mem_out;
    logic        zero_out, stall, mdu_busy;

    int checks = 0;
    int failures = 0;
    int ncyc;
    bit bubble_ok;

    ex_stage_mdu dut (
        .clk(clk), .rst(rst),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .shamt_in(shamt_in),
        .funct_in(funct_in), .immed_in(immed_in), .rd1_in(rd1_in), .rd2_in(rd2_in),
        .wb_in(wb_in), .mem_in(mem_in), .exe_in(exe_in),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .alu_out(alu_out), .store_out(store_out), .dst_out(dst_out),
        .wb_out(wb_out), .mem_out(mem_out), .zero_out(zero_out),
        .stall(stall), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exe_in   = 4'b1010;
        wb_in    = 2'b10;
        mem_in   = 2'b00;
        funct_in = f;
        rd1_in   = a;
        rd2_in   = b;
    endtask

    // Launch a multi-cycle op and count the stalled cycles until release.
    task automatic run_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output int n, output bit bok);
        rtype(f, a, b);
        rs_in  = 5'd1;
        rt_in  = 5'd2;
        wb_in  = 2'b11;
        mem_in = 2'b11;
        #1;
        n   = 0;
        bok = 1'b1;
        while (stall === 1'b1 && n < 100) begin
            n++;
            if (wb_out !== 2'b00 || mem_out !== 2'b00) bok = 1'b0;
            tick();
            if (n == 1) begin
                rd1_in = 32'hDEAD_BEEF;
                rd2_in = 32'h0BAD_F00D;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rs_in = 5'd0; rt_in = 5'd0; rd_in = 5'd0; shamt_in = 5'd0;
        funct_in = 6'd0; immed_in = 32'd0; rd1_in = 32'd0; rd2_in = 32'd0;
        wb_in = 2'b00; mem_in = 2'b00; exe_in = 4'b0000;
        exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_data = 32'd0;
        memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;
        tick();
        tick();
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_busy", 32'(mdu_busy), 32'd0);
        rst = 1'b0;
        rtype(6'h10, 32'd0, 32'd0);
        #1;
        chk("reset_hi", alu_out, 32'd0);

        // add, no forwarding
        rs_in = 5'd1; rt_in = 5'd2; rd_in = 5'd3;
        rtype(6'h20, 32'd5, 32'd7);
        #1;
        chk("add_res", alu_out, 32'd12);
        chk("add_dst", 32'(dst_out), 32'd3);
        chk("add_stall", 32'(stall), 32'd0);
        chk("add_wb", 32'(wb_out), 32'd2);

        // forwarding priority
        exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_data = 32'd100;
        memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_data = 32'd200;
        rs_in = 5'd4; rt_in = 5'd2;
        rtype(6'h22, 32'd50, 32'd1);
        #1;
        chk("fwd_exmem", alu_out, 32'd99);
        exmem_regwrite = 1'b0;
        #1;
        chk("fwd_memwb", alu_out, 32'd199);
        exmem_regwrite = 1'b1;
        rs_in = 5'd0;
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        chk("fwd_r0", alu_out, 32'd49);
        exmem_rd = 5'd4; memwb_rd = 5'd4;
        rs_in = 5'd1; rt_in = 5'd4;
        #1;
        chk("fwd_store", store_out, 32'd100);
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;

        // lw address generation
        rs_in = 5'd1; rt_in = 5'd9; rd_in = 5'd3;
        exe_in = 4'b0100; wb_in = 2'b11; mem_in = 2'b10;
        rd1_in = 32'h0000_1000; immed_in = 32'hFFFF_FFFC;
        #1;
        chk("lw_addr", alu_out, 32'h0000_0FFC);
        chk("lw_dst", 32'(dst_out), 32'd9);
        chk("lw_wb", 32'(wb_out), 32'd3);
        chk("lw_mem", 32'(mem_out), 32'd2);

        // beq compare and zero flag
        exe_in = 4'b0001; rd1_in = 32'd77; rd2_in = 32'd77; rt_in = 5'd2;
        #1;
        chk("beq_zero", 32'(zero_out), 32'd1);

        // logic/compare/shift functs
        rtype(6'h2A, 32'hFFFF_FFFF, 32'd1);
        #1;
        chk("slt_signed", alu_out, 32'd1);
        rtype(6'h24, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        #1;
        chk("and", alu_out, 32'h00F0_000F);
        rtype(6'h02, 32'd0, 32'h8000_0000);
        shamt_in = 5'd4;
        #1;
        chk("srl", alu_out, 32'h0800_0000);
        exe_in = 4'b0111; rd1_in = 32'h0000_0F00; immed_in = 32'h0000_00F0;
        #1;
        chk("ori", alu_out, 32'h0000_0FF0);
        rtype(6'h3F, 32'd3, 32'd4);
        #1;
        chk("bad_funct", alu_out, 32'd0);
`ifndef MDU_DIVU_EN
        rtype(6'h1B, 32'd17, 32'd5);
        #1;
        chk("divu_off_res", alu_out, 32'd0);
        chk("divu_off_stall", 32'(stall), 32'd0);
`endif

        // multu with full stall window and bubbles
        run_mdu(6'h19, 32'hFFFF_FFFF, 32'h0000_0002, ncyc, bubble_ok);
        chk("mul_stall_cycles", 32'(ncyc), 32'd33);
        chk("mul_bubbles", 32'(bubble_ok), 32'd1);
        chk("mul_done_busy", 32'(mdu_busy), 32'd1);
        rtype(6'h10, 32'd0, 32'd0);
        tick();
        chk("mfhi", alu_out, 32'h0000_0001);
        chk("mfhi_busy", 32'(mdu_busy), 32'd0);
        rtype(6'h12, 32'd0, 32'd0);
        tick();
        chk("mflo", alu_out, 32'hFFFF_FFFE);

        run_mdu(6'h19, 32'h1234_5678, 32'h0000_0100, ncyc, bubble_ok);
        rtype(6'h10, 32'd0, 32'd0);
        tick();
        chk("mul2_hi", alu_out, 32'h0000_0012);
        rtype(6'h12, 32'd0, 32'd0);
        #1;
        chk("mul2_lo", alu_out, 32'h3456_7800);

        // reset in the 10th busy cycle aborts the operation
        rtype(6'h19, 32'd7, 32'd9);
        #1;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_pre_busy", 32'(mdu_busy), 32'd1);
        rst = 1'b1;
        rtype(6'h10, 32'd0, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_busy", 32'(mdu_busy), 32'd0);
        chk("abort_hi", alu_out, 32'd0);

`ifdef MDU_DIVU_EN
        run_mdu(6'h1B, 32'd17, 32'd5, ncyc, bubble_ok);
        chk("div_stall_cycles", 32'(ncyc), 32'd33);
        rtype(6'h12, 32'd0, 32'd0);
        tick();
        chk("div_lo", alu_out, 32'd3);
        rtype(6'h10, 32'd0, 32'd0);
        #1;
        chk("div_hi", alu_out, 32'd2);
        run_mdu(6'h1B, 32'd9, 32'd0, ncyc, bubble_ok);
        chk("div0_stall_cycles", 32'(ncyc), 32'd33);
        rtype(6'h12, 32'd0, 32'd0);
        tick();
        chk("div0_lo", alu_out, 32'hFFFF_FFFF);
        rtype(6'h10, 32'd0, 32'd0);
        #1;
        chk("div0_hi", alu_out, 32'd9);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
